segment_capture: RTL and testbench

- Receiver/decoder for the multiplexed 7-segment clock display stream: digit-select plus segment pattern in, time value out.
- Samples the 4 digit-select lines and 7 segment lines, glitch-filters them, and decodes each pattern back to a BCD digit.
- Assembles a 4-digit frame, range-checks it, and publishes {hours, minutes} as 12 bits after two identical consecutive frames.
- Used as an on-chip loopback monitor and as the bench-side checker for the display path.

---
 rtl/segment_capture.sv | 207 ++++++++++++++++++++
 tb/tb_segment_capture.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/segment_capture.sv
// segment_capture: receiver/decoder for a multiplexed 4-digit 7-segment clock display stream.
// Registers and glitch-filters digit-select/segment lines, decodes each stable pattern to
// BCD, assembles a 4-digit frame, range-checks it and publishes {hours, minutes} once two
// identical consecutive frames have been seen.
//
// Ports:
//   clock        system clock
//   reset        synchronous reset, active low
//   bytee[3:0]   digit select, one-hot: 0=min ones, 1=min tens, 2=hour ones, 3=hour tens
//   segment[6:0] segment pattern {g,f,e,d,c,b,a}, active high
//   data_out     {hours[5:0], minutes[5:0]} binary, held between updates
//   data_valid   one-cycle pulse when data_out updates
//   seg_err      one-cycle pulse: accepted digit had an undecodable pattern
//   range_err    one-cycle pulse: complete frame out of range
//   timeout_err  one-cycle pulse: frame not completed in time
module segment_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  bytee,
  input  logic [6:0]  segment,
  output logic [11:0] data_out,
  output logic        data_valid,
  output logic        seg_err,
  output logic        range_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StCollect, StCheck} state_e;

  // Count value seen in the cycle before the dwell reaches STABLE_CYCLES samples.
  localparam logic [3:0]  AcceptCnt = 4'(STABLE_CYCLES - 2);
  localparam logic [15:0] TmoLast   = 16'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       byte_q, byte_d, byte_p_q, byte_p_d;
  logic [6:0]       seg_q, seg_d, seg_p_q, seg_p_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [15:0]      last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic [11:0]      out_q, out_d;
  logic             valid_q, valid_d;
  logic             seg_err_q, seg_err_d;
  logic             range_err_q, range_err_d;
  logic             tmo_err_q, tmo_err_d;

  logic       same, one_hot, accept, dec_ok;
  logic [3:0] dec_val;
  logic [3:0] mask_new;
  logic [6:0] hrs, mins;

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (seg_q)
      7'h3F:   dec_val = 4'd0;
      7'h06:   dec_val = 4'd1;
      7'h5B:   dec_val = 4'd2;
      7'h4F:   dec_val = 4'd3;
      7'h66:   dec_val = 4'd4;
      7'h6D:   dec_val = 4'd5;
      7'h7D:   dec_val = 4'd6;
      7'h07:   dec_val = 4'd7;
      7'h7F:   dec_val = 4'd8;
      7'h6F:   dec_val = 4'd9;
      default: dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    byte_d      = bytee;
    seg_d       = segment;
    byte_p_d    = byte_q;
    seg_p_d     = seg_q;
    state_d     = state_q;
    mask_d      = mask_q;
    dig_d       = dig_q;
    tmo_d       = tmo_q;
    last_d      = last_q;
    last_vld_d  = last_vld_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    seg_err_d   = 1'b0;
    range_err_d = 1'b0;
    tmo_err_d   = 1'b0;

    same    = (byte_q == byte_p_q) && (seg_q == seg_p_q);
    one_hot = (byte_q != 4'd0) && ((byte_q & (byte_q - 4'd1)) == 4'd0);
    if (!same)                cnt_d = 4'd0;
    else if (cnt_q == 4'hF)   cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 4'd1;
    accept = same && (cnt_q == AcceptCnt) && one_hot;

    mask_new = mask_q | byte_q;
    hrs      = 7'(dig_q[3]) * 7'd10 + 7'(dig_q[2]);
    mins     = 7'(dig_q[1]) * 7'd10 + 7'(dig_q[0]);

    unique case (state_q)
      StIdle: begin
        tmo_d = 16'd0;
        if (accept) begin
          if (!dec_ok) begin
            seg_err_d = 1'b1;
            mask_d    = 4'd0;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (byte_q[i]) dig_d[i] = dec_val;
            end
            mask_d  = mask_new;
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        tmo_d = tmo_q + 16'd1;
        // Timeout has priority: a digit accepted in the same cycle is dropped.
        if (tmo_q == TmoLast) begin
          tmo_err_d = 1'b1;
          mask_d    = 4'd0;
          tmo_d     = 16'd0;
          state_d   = StIdle;
        end else if (accept) begin
          if (!dec_ok) begin
            seg_err_d = 1'b1;
            mask_d    = 4'd0;
            tmo_d     = 16'd0;
            state_d   = StIdle;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (byte_q[i]) dig_d[i] = dec_val;
            end
            mask_d = mask_new;
            if (mask_new == 4'hF) state_d = StCheck;
          end
        end
      end
      StCheck: begin
        tmo_d   = 16'd0;
        mask_d  = 4'd0;
        state_d = StIdle;
        if (hrs > 7'd23 || mins > 7'd59) begin
          range_err_d = 1'b1;
          last_vld_d  = 1'b0;
        end else begin
          // Publish only when this frame repeats the previous in-range frame.
          if (last_vld_q && (dig_q == last_q)) begin
            out_d   = {hrs[5:0], mins[5:0]};
            valid_d = 1'b1;
          end
          last_d     = dig_q;
          last_vld_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      byte_q      <= 4'd0;
      seg_q       <= 7'd0;
      byte_p_q    <= 4'd0;
      seg_p_q     <= 7'd0;
      cnt_q       <= 4'd0;
      mask_q      <= 4'd0;
      dig_q       <= '0;
      tmo_q       <= 16'd0;
      last_q      <= 16'd0;
      last_vld_q  <= 1'b0;
      out_q       <= 12'd0;
      valid_q     <= 1'b0;
      seg_err_q   <= 1'b0;
      range_err_q <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      seg_q       <= seg_d;
      byte_p_q    <= byte_p_d;
      seg_p_q     <= seg_p_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      dig_q       <= dig_d;
      tmo_q       <= tmo_d;
      last_q      <= last_d;
      last_vld_q  <= last_vld_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      seg_err_q   <= seg_err_d;
      range_err_q <= range_err_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign data_out    = out_q;
  assign data_valid  = valid_q;
  assign seg_err     = seg_err_q;
  assign range_err   = range_err_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_segment_capture.sv
// Self-checking bench for segment_capture: directed scenarios plus randomized display
// streams, compared every cycle against a transaction-level reference model.
module tb_segment_capture;

  localparam int S   = 4;
  localparam int TMO = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  bytee = 4'd0;
  logic [6:0]  segment = 7'd0;
  logic [11:0] data_out;
  logic        data_valid, seg_err, range_err, timeout_err;

  always #5 clock = ~clock;

  segment_capture #(
    .STABLE_CYCLES(S),
    .TIMEOUT      (TMO)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .bytee      (bytee),
    .segment    (segment),
    .data_out   (data_out),
    .data_valid (data_valid),
    .seg_err    (seg_err),
    .range_err  (range_err),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  bit [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int decode(input bit [6:0] p);
    for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  // Reference model: sample history as run length, frame as digit array plus presence flags.
  bit [3:0] cur_b;
  bit [6:0] cur_s;
  int       run = 1;
  int       now = 0;
  int       dig [4];
  bit       have [4];
  bit       pending;
  int       frame_start;
  int       last_fr;
  bit       last_valid;
  int       e_out;
  bit       e_valid, e_seg, e_range, e_tmo;
  int       n_valid, n_seg, n_range, n_tmo;

  task automatic model_next(input bit [3:0] b, input bit [6:0] s, input bit rst_n);
    int  d, h, m, fr, pos;
    bit  active;
    e_valid = 0; e_seg = 0; e_range = 0; e_tmo = 0;
    if (!rst_n) begin
      e_out = 0; pending = 0; last_valid = 0;
      for (int i = 0; i < 4; i++) have[i] = 0;
      cur_b = 0; cur_s = 0; run = 1; now++;
      return;
    end
    active = have[0] | have[1] | have[2] | have[3];
    if (pending) begin
      h  = dig[3] * 10 + dig[2];
      m  = dig[1] * 10 + dig[0];
      fr = h * 100 + m;
      if (h > 23 || m > 59) begin
        e_range = 1; last_valid = 0;
      end else begin
        if (last_valid && fr == last_fr) begin
          e_valid = 1; e_out = h * 64 + m;
        end
        last_fr = fr; last_valid = 1;
      end
      for (int i = 0; i < 4; i++) have[i] = 0;
      pending = 0;
    end else if (active && (now - frame_start == TMO)) begin
      e_tmo = 1;
      for (int i = 0; i < 4; i++) have[i] = 0;
    end else if ($countones(cur_b) == 1 && run == S) begin
      d = decode(cur_s);
      if (d < 0) begin
        e_seg = 1;
        for (int i = 0; i < 4; i++) have[i] = 0;
      end else begin
        pos = 0;
        for (int i = 0; i < 4; i++) if (cur_b[i]) pos = i;
        if (!active) frame_start = now;
        dig[pos] = d; have[pos] = 1;
        if (have[0] && have[1] && have[2] && have[3]) pending = 1;
      end
    end
    if (b == cur_b && s == cur_s) run++;
    else run = 1;
    cur_b = b; cur_s = s; now++;
  endtask

  task automatic step(input bit [3:0] b, input bit [6:0] s, input bit rst_n);
    @(negedge clock);
    bytee = b; segment = s; reset = rst_n;
    model_next(b, s, rst_n);
    @(posedge clock);
    #1;
    check_eq("data_out", data_out, e_out);
    check_eq("data_valid", data_valid, e_valid);
    check_eq("seg_err", seg_err, e_seg);
    check_eq("range_err", range_err, e_range);
    check_eq("timeout_err", timeout_err, e_tmo);
    n_valid += data_valid; n_seg += seg_err; n_range += range_err; n_tmo += timeout_err;
  endtask

  task automatic blank(input int n);
    repeat (n) step(4'd0, 7'd0, 1'b1);
  endtask

  task automatic digit(input int pos, input bit [6:0] p, input int hold);
    repeat (hold) step(4'(1 << pos), p, 1'b1);
  endtask

  task automatic frame(input int h1, input int h0, input int m1, input int m0);
    digit(0, pats[m0], 8); blank(2);
    digit(1, pats[m1], 8); blank(2);
    digit(2, pats[h0], 8); blank(2);
    digit(3, pats[h1], 8); blank(2);
  endtask

  task automatic clear_counts();
    n_valid = 0; n_seg = 0; n_range = 0; n_tmo = 0;
  endtask

  initial begin
    repeat (3) step(4'd0, 7'd0, 1'b0);
    check_eq("reset_out", data_out, 0);
    blank(2);

    // Out-of-range frames never publish.
    clear_counts();
    frame(2, 5, 1, 0); frame(2, 5, 1, 0);
    check_eq("range_cnt", n_range, 2);
    check_eq("range_valid_cnt", n_valid, 0);
    check_eq("range_out", data_out, 0);

    // Two identical frames of 12:34.
    clear_counts();
    frame(1, 2, 3, 4); frame(1, 2, 3, 4);
    check_eq("t1234_valid_cnt", n_valid, 1);
    check_eq("t1234_out", data_out, 12'h322);
    check_eq("t1234_err_cnt", n_seg + n_range + n_tmo, 0);

    // One dwell one sample short of acceptance.
    clear_counts();
    digit(0, pats[4], 8); blank(2);
    digit(1, pats[3], S - 1); blank(2);
    digit(1, pats[3], S); blank(2);
    digit(2, pats[2], 8); blank(2);
    digit(3, pats[1], 8); blank(2);
    check_eq("short_seg_cnt", n_seg, 0);
    check_eq("short_valid_cnt", n_valid, 1);

    // Undecodable pattern.
    clear_counts();
    digit(0, pats[4], 8); blank(2);
    digit(1, 7'h00, 8); blank(3);
    check_eq("seg_cnt", n_seg, 1);
    check_eq("seg_out", data_out, 12'h322);

    // Incomplete frame times out, then 07:05 twice.
    clear_counts();
    digit(0, pats[1], 8); blank(2);
    digit(1, pats[2], 8); blank(2);
    digit(2, pats[3], 8);
    blank(TMO);
    check_eq("tmo_cnt", n_tmo, 1);
    frame(0, 7, 0, 5); frame(0, 7, 0, 5);
    check_eq("t0705_out", data_out, 12'h1C5);

    // Reset mid-frame discards everything.
    frame(1, 2, 3, 4);
    digit(0, pats[4], 8); blank(2);
    digit(1, pats[3], 8);
    step(4'b0010, pats[3], 1'b0);
    check_eq("midreset_out", data_out, 0);
    clear_counts();
    frame(1, 2, 3, 4);
    check_eq("fresh1_valid_cnt", n_valid, 0);
    frame(1, 2, 3, 4);
    check_eq("fresh2_valid_cnt", n_valid, 1);
    check_eq("fresh2_out", data_out, 12'h322);

    // Randomized streams.
    for (int it = 0; it < 40; it++) begin
      int t [4];
      int reps;
      t[3] = $urandom_range(0, 2); t[2] = $urandom_range(0, 9);
      t[1] = $urandom_range(0, 6); t[0] = $urandom_range(0, 9);
      reps = $urandom_range(1, 3);
      repeat (reps) begin
        for (int p = 0; p < 4; p++) begin
          bit [6:0] pat;
          pat = pats[t[p]];
          if ($urandom_range(0, 19) == 0) pat = 7'($urandom);
          if ($urandom_range(0, 24) == 0) step(4'b0011, pat, 1'b1);
          digit(p, pat, $urandom_range(2, 9));
          blank($urandom_range(1, 3));
        end
      end
    end
    blank(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
